// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and downstream memory port signals; master is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [DATA_W/8-1:0] d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              m_valid;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [DATA_W/8-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;
  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
    output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_valid, m_write, m_addr, m_size, m_strobe, m_wdata
  );
  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
    input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
           m_valid, m_write, m_addr, m_size, m_strobe, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data sides, one transaction outstanding.
// ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed d-side priority.
module mem_port_arbiter (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, next_state;
  logic last_grant;
  logic idle, grant_i, grant_d;
  always_comb begin
    idle = state == IDLE;
`ifdef ROUND_ROBIN_EN
    grant_d = bus.d_valid && (!bus.i_valid || !last_grant);
`else
    grant_d = bus.d_valid;
`endif
    grant_i = bus.i_valid && !grant_d;
    bus.i_addr_ok = idle && grant_i;
    bus.d_addr_ok = idle && grant_d;
    bus.i_data_ok = state == BUSY_I && bus.m_ready;
    bus.d_data_ok = state == BUSY_D && bus.m_ready;
    bus.i_rdata = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
    bus.m_valid = !idle;
    bus.m_write = |bus.m_strobe;
    next_state = idle ? (grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE)
                      : (bus.m_ready ? IDLE : state);
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  // last_grant: 1 = d-side won the most recent arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_size   <= '0;
      bus.m_strobe <= '0;
      bus.m_wdata  <= '0;
    end else if (idle && (grant_i || grant_d)) begin
      last_grant   <= grant_d;
      bus.m_addr   <= grant_d ? bus.d_addr : bus.i_addr;
      bus.m_size   <= grant_d ? bus.d_size : 3'd2;
      bus.m_strobe <= grant_d ? bus.d_strobe : '0;
      bus.m_wdata  <= grant_d ? bus.d_wdata : '0;
    end else begin
      last_grant   <= last_grant;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with a data_ok scoreboard.
module tb_mem_port_arbiter;
  logic clk = 0;
  logic reset = 1;
  int n_run = 0;
  int n_fail = 0;
  int d_cnt = 0;
  typedef struct {logic side; logic chkd; logic [31:0] rd;} exp_t;
  exp_t q[$];
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic expect_data(input logic side, input logic chkd, input logic [31:0] rd);
    exp_t e;
    e.side = side;
    e.chkd = chkd;
    e.rd = rd;
    q.push_back(e);
  endtask
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (!reset) begin
      d_cnt += int'(bus.d_data_ok);
      if ((bus.i_addr_ok || bus.d_addr_ok) && (bus.i_data_ok || bus.d_data_ok))
        chk("addr_data_excl", {bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok}, 0);
      if (bus.i_data_ok || bus.d_data_ok) begin
        if (q.size() == 0)
          chk("unexp_data_ok", {bus.i_data_ok, bus.d_data_ok}, 0);
        else begin
          e = q.pop_front();
          chk("data_ok_side", {bus.i_data_ok, bus.d_data_ok}, e.side ? 2'b01 : 2'b10);
          if (e.chkd) chk("rdata", e.side ? bus.d_rdata : bus.i_rdata, e.rd);
        end
      end
    end
  end
  initial begin
    logic first;
    int d0;
    bus.i_valid = 0; bus.i_addr = 0; bus.d_valid = 0; bus.d_addr = 0; bus.d_size = 0;
    bus.d_strobe = 0; bus.d_wdata = 0; bus.m_ready = 0; bus.m_rdata = 0;
    cyc(); cyc();
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); #1;
      chk("idle_out", {bus.i_addr_ok, bus.d_addr_ok, bus.i_data_ok, bus.d_data_ok, bus.m_valid,
                       bus.m_write, bus.m_size, bus.m_strobe}, 0);
      chk("idle_maddr", {bus.m_addr, bus.m_wdata}, 0);
    end
    cyc(); bus.i_valid = 1; bus.i_addr = 32'hBFC00000; #1;
    chk("fetch_addr_ok", {bus.i_addr_ok, bus.d_addr_ok}, 2'b10);
    cyc(); bus.m_ready = 1; bus.m_rdata = 32'h3C08BFC0; expect_data(0, 1, 32'h3C08BFC0); #1;
    chk("fetch_m", {bus.m_valid, bus.m_write, bus.m_size, bus.m_strobe}, {2'b10, 3'd2, 4'h0});
    chk("fetch_maddr", bus.m_addr, 32'hBFC00000);
    chk("fetch_data_ok", {bus.i_addr_ok, bus.i_data_ok}, 2'b01);
    cyc(); bus.i_valid = 0; bus.m_ready = 0; #1;
    chk("fetch_done", {bus.m_valid, bus.i_data_ok}, 0);
    d0 = d_cnt;
    cyc(); bus.d_valid = 1; bus.d_addr = 32'h80000004; bus.d_size = 2; bus.d_strobe = 4'hF;
    bus.d_wdata = 32'hDEADBEEF; #1;
    chk("store_addr_ok", {bus.i_addr_ok, bus.d_addr_ok}, 2'b01);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("store_hold", {bus.m_valid, bus.m_write, bus.m_size, bus.m_strobe, bus.d_data_ok, bus.d_addr_ok},
          {2'b11, 3'd2, 4'hF, 2'b00});
      chk("store_fields", {bus.m_addr, bus.m_wdata}, {32'h80000004, 32'hDEADBEEF});
    end
    cyc(); bus.m_ready = 1; expect_data(1, 0, 0); #1;
    chk("store_data_ok", bus.d_data_ok, 1);
    cyc(); bus.d_valid = 0; bus.d_strobe = 0; bus.m_ready = 0; #1;
    chk("store_idle", {bus.m_valid, bus.d_data_ok}, 0);
    cyc(); #1;
    chk("store_once", d_cnt - d0, 1);
`ifdef ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    bus.i_valid = 1; bus.i_addr = 32'h00001000; bus.d_valid = 1; bus.d_addr = 32'h00002000; bus.d_size = 1;
    #1;
    chk("tie_first", {bus.i_addr_ok, bus.d_addr_ok}, first ? 2'b01 : 2'b10);
    cyc(); bus.m_ready = 1; bus.m_rdata = 32'h11111111; expect_data(first, 1, 32'h11111111); #1;
    chk("tie_first_addr", bus.m_addr, first ? 32'h00002000 : 32'h00001000);
    chk("tie_first_size", bus.m_size, first ? 3'd1 : 3'd2);
    cyc(); bus.m_ready = 0; if (first) bus.d_valid = 0; else bus.i_valid = 0; #1;
    chk("tie_second", {bus.i_addr_ok, bus.d_addr_ok}, first ? 2'b10 : 2'b01);
    cyc(); bus.m_ready = 1; bus.m_rdata = 32'h22222222; expect_data(!first, 1, 32'h22222222); #1;
    chk("tie_second_addr", bus.m_addr, first ? 32'h00001000 : 32'h00002000);
    cyc(); bus.m_ready = 0; bus.i_valid = 0; bus.d_valid = 0; #1;
    chk("tie_done", bus.m_valid, 0);
    cyc(); bus.d_valid = 1; bus.d_addr = 32'h00003000; bus.d_size = 2; #1;
    chk("drop_addr_ok", bus.d_addr_ok, 1);
    cyc(); bus.d_valid = 0; #1;
    chk("drop_busy", {bus.m_valid, bus.d_data_ok}, 2'b10);
    cyc(); bus.m_ready = 1; bus.m_rdata = 32'h33333333; expect_data(1, 1, 32'h33333333); #1;
    chk("drop_data_ok", bus.d_data_ok, 1);
    for (int k = 0; k < 2; k++) begin
      cyc(); bus.m_ready = 0; #1;
      chk("drop_no_regrant", {bus.m_valid, bus.d_addr_ok}, 0);
    end
    cyc(); bus.d_valid = 1; bus.d_addr = 32'h80000008; bus.d_strobe = 4'h3; bus.d_wdata = 32'h0000CAFE; #1;
    chk("rst_addr_ok", bus.d_addr_ok, 1);
    cyc(); bus.d_valid = 0; bus.d_strobe = 0; reset = 1; #1;
    chk("rst_busy", {bus.m_valid, bus.m_write}, 2'b11);
    cyc(); reset = 0; #1;
    chk("rst_idle", {bus.m_valid, bus.m_write, bus.d_data_ok}, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.m_ready = 1; #1;
      chk("rst_no_data_ok", {bus.i_data_ok, bus.d_data_ok, bus.m_valid}, 0);
    end
    cyc(); bus.m_ready = 0; #5;
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
